pipeline_hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Generates PC enable and the FD/DE hold/flush controls.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_if.sv | 50 +++++
 rtl/load_use_detector.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 179 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller slice.
//   - hazard_state_t   : 2-bit sequencer state encoding
//   - MEM_OWNER_FETCH / MEM_OWNER_DATA : values driven on mem_owner
//   - REG_NUM_WIDTH_DEF: default width of register-number fields
// ----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_NUM_WIDTH_DEF = 3;

  localparam logic MEM_OWNER_FETCH = 1'b0;
  localparam logic MEM_OWNER_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_INT_DRAIN  = 2'd1,
    ST_INT_PUSH   = 2'd2,
    ST_INT_VECTOR = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/hazard_if.sv
// ----------------------------------------------------------------------------
// hazard_if
// Bundles the hazard inputs coming from the pipeline stages and the stall/
// flush/interrupt controls going back to them.
//   slave  modport : the hazard controller (reads hazards, drives controls)
//   master modport : the pipeline side (drives hazards, reads controls)
// Parameters: REG_NUM_WIDTH (register-number width),
//             PERF_CNT_WIDTH (width of stall_count)
// ----------------------------------------------------------------------------
interface hazard_if #(
  parameter int REG_NUM_WIDTH  = 3,
  parameter int PERF_CNT_WIDTH = 16
);

  logic [REG_NUM_WIDTH-1:0]  fd_src1_num;
  logic                      fd_src1_valid;
  logic [REG_NUM_WIDTH-1:0]  fd_src2_num;
  logic                      fd_src2_valid;
  logic                      de_mem_read;
  logic [REG_NUM_WIDTH-1:0]  de_dst_num;
  logic                      em_mem_access;
  logic                      branch_taken;
  logic                      int_req;

  logic                      pc_en;
  logic                      fd_en;
  logic                      fd_flush;
  logic                      de_flush;
  logic                      mem_owner;
  logic                      int_push;
  logic                      int_vector_load;
  logic                      int_ack;
  logic                      busy;
  logic [PERF_CNT_WIDTH-1:0] stall_count;

  modport slave (
    input  fd_src1_num, fd_src1_valid, fd_src2_num, fd_src2_valid,
           de_mem_read, de_dst_num, em_mem_access, branch_taken, int_req,
    output pc_en, fd_en, fd_flush, de_flush, mem_owner,
           int_push, int_vector_load, int_ack, busy, stall_count
  );

  modport master (
    output fd_src1_num, fd_src1_valid, fd_src2_num, fd_src2_valid,
           de_mem_read, de_dst_num, em_mem_access, branch_taken, int_req,
    input  pc_en, fd_en, fd_flush, de_flush, mem_owner,
           int_push, int_vector_load, int_ack, busy, stall_count
  );

endinterface

// File: rtl/load_use_detector.sv
// ----------------------------------------------------------------------------
// load_use_detector
// Combinational comparator: flags when the instruction in decode reads the
// register that the load currently in DE is about to write.
// Ports: src1_num/src1_valid, src2_num/src2_valid (decode sources),
//        mem_read/dst_num (DE load and destination), load_use (result)
// ----------------------------------------------------------------------------
module load_use_detector #(
  parameter int REG_NUM_WIDTH = 3
) (
  input  logic [REG_NUM_WIDTH-1:0] src1_num,
  input  logic                     src1_valid,
  input  logic [REG_NUM_WIDTH-1:0] src2_num,
  input  logic                     src2_valid,
  input  logic                     mem_read,
  input  logic [REG_NUM_WIDTH-1:0] dst_num,
  output logic                     load_use
);

  assign load_use = mem_read &
                    ((src1_valid & (src1_num == dst_num)) |
                     (src2_valid & (src2_num == dst_num)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use,
// fetch/memory-stage port conflicts and taken branches, and runs the
// interrupt entry sequence (drain, push PC, load vector).
// Ports: clk, reset (synchronous, active-high), bus (hazard_if.slave)
// Parameters: REG_NUM_WIDTH, DRAIN_CYCLES (>=1), PERF_CNT_WIDTH
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall
// counter; otherwise stall_count is tied to zero.
// ----------------------------------------------------------------------------
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_NUM_WIDTH  = REG_NUM_WIDTH_DEF,
  parameter int DRAIN_CYCLES   = 3,
  parameter int PERF_CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  hazard_state_t    state, state_next;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_next;
  logic             load_use;
  logic             pc_en, fd_en, fd_flush, de_flush, mem_owner;
  logic             int_push, int_vector_load, int_ack, busy;

  load_use_detector #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_lud (
    .src1_num   (bus.fd_src1_num),
    .src1_valid (bus.fd_src1_valid),
    .src2_num   (bus.fd_src2_num),
    .src2_valid (bus.fd_src2_valid),
    .mem_read   (bus.de_mem_read),
    .dst_num    (bus.de_dst_num),
    .load_use   (load_use)
  );

  // State and drain counter; reset always lands in RUN with the counter clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Next state and control outputs. Within RUN and INT_DRAIN a taken branch
  // wins over a load-use stall, since the stalled instruction is squashed anyway.
  always_comb begin
    state_next      = state;
    drain_cnt_next  = drain_cnt;
    pc_en           = 1'b0;
    fd_en           = 1'b1;
    fd_flush        = 1'b0;
    de_flush        = 1'b0;
    mem_owner       = MEM_OWNER_FETCH;
    int_push        = 1'b0;
    int_vector_load = 1'b0;
    int_ack         = 1'b0;
    busy            = (state != ST_RUN);

    case (state)
      ST_RUN: begin
        if (bus.branch_taken) begin
          pc_en     = 1'b1;
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
          mem_owner = bus.em_mem_access;
        end else if (load_use) begin
          fd_en     = 1'b0;
          de_flush  = 1'b1;
          mem_owner = bus.em_mem_access;
        end else if (bus.em_mem_access) begin
          fd_flush  = 1'b1;
          mem_owner = MEM_OWNER_DATA;
        end else begin
          pc_en     = 1'b1;
        end
        // A branch in the same cycle defers the interrupt so its target is kept.
        if (bus.int_req && !bus.branch_taken) begin
          state_next     = ST_INT_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end

      ST_INT_DRAIN: begin
        fd_flush  = 1'b1;
        mem_owner = bus.em_mem_access;
        if (bus.branch_taken) begin
          pc_en    = 1'b1;
          de_flush = 1'b1;
        end else if (load_use) begin
          fd_en    = 1'b0;
          fd_flush = 1'b0;
          de_flush = 1'b1;
        end
        // The counter freezes only for a load-use bubble; a squashed stall does not.
        if (bus.branch_taken || !load_use) begin
          if (drain_cnt == '0) begin
            state_next = ST_INT_PUSH;
          end else begin
            drain_cnt_next = drain_cnt - 1'b1;
          end
        end
      end

      ST_INT_PUSH: begin
        mem_owner = MEM_OWNER_DATA;
        fd_flush  = 1'b1;
        de_flush  = 1'b1;
        // A data access still in EM keeps the port; wait instead of double-driving it.
        if (!bus.em_mem_access) begin
          int_push   = 1'b1;
          state_next = ST_INT_VECTOR;
        end
      end

      ST_INT_VECTOR: begin
        int_vector_load = 1'b1;
        pc_en           = 1'b1;
        int_ack         = 1'b1;
        fd_flush        = 1'b1;
        de_flush        = 1'b1;
        state_next      = ST_RUN;
      end

      default: begin
        state_next     = ST_RUN;
        drain_cnt_next = '0;
      end
    endcase

    if (reset) begin
      pc_en           = 1'b0;
      fd_en           = 1'b0;
      fd_flush        = 1'b1;
      de_flush        = 1'b1;
      mem_owner       = MEM_OWNER_FETCH;
      int_push        = 1'b0;
      int_vector_load = 1'b0;
      int_ack         = 1'b0;
      busy            = 1'b0;
    end
  end

  assign bus.pc_en           = pc_en;
  assign bus.fd_en           = fd_en;
  assign bus.fd_flush        = fd_flush;
  assign bus.de_flush        = de_flush;
  assign bus.mem_owner       = mem_owner;
  assign bus.int_push        = int_push;
  assign bus.int_vector_load = int_vector_load;
  assign bus.int_ack         = int_ack;
  assign bus.busy            = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cnt;

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {PERF_CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_count = stall_cnt;
`else
  assign bus.stall_count = {PERF_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Drives directed hazard scenarios followed by random traffic into
// pipeline_hazard_controller and compares every control output, every cycle,
// against a behavioural model of the hazard and interrupt rules.
// Build with HAZARD_PERF_CNT_EN defined to also check the stall counter.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int RW    = 3;
  localparam int PW    = 16;
  localparam int DRAIN = 3;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_PUSH  = 2;
  localparam int M_VEC   = 3;

  logic clk = 1'b0;
  logic reset;

  hazard_if #(.REG_NUM_WIDTH(RW), .PERF_CNT_WIDTH(PW)) bus ();

  pipeline_hazard_controller #(
    .REG_NUM_WIDTH  (RW),
    .DRAIN_CYCLES   (DRAIN),
    .PERF_CNT_WIDTH (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: which phase of interrupt entry we are in, and how many
  // fetch-off drain cycles are still owed before the PC push.
  int          mode       = M_RUN;
  int          drain_left = 0;
  logic [PW-1:0] exp_stall = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t mode=%0d)", tag, got, exp, $time, mode);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic [RW-1:0] s1, input logic s1v,
                               input logic [RW-1:0] s2, input logic s2v,
                               input logic mr, input logic [RW-1:0] dst,
                               input logic em, input logic br, input logic irq);
    logic lu;
    logic e_pc, e_fden, e_fdfl, e_defl, e_own, e_push, e_vec, e_ack, e_busy;
    @(negedge clk);
    reset             = rst;
    bus.fd_src1_num   = s1;
    bus.fd_src1_valid = s1v;
    bus.fd_src2_num   = s2;
    bus.fd_src2_valid = s2v;
    bus.de_mem_read   = mr;
    bus.de_dst_num    = dst;
    bus.em_mem_access = em;
    bus.branch_taken  = br;
    bus.int_req       = irq;
    #1;
    lu = mr && ((s1v && (s1 == dst)) || (s2v && (s2 == dst)));
    {e_pc, e_fden, e_fdfl, e_defl, e_own, e_push, e_vec, e_ack, e_busy} = '0;
    if (rst) begin
      e_fdfl = 1'b1;
      e_defl = 1'b1;
    end else begin
      case (mode)
        M_RUN: begin
          if (br)      begin e_pc = 1; e_fden = 1; e_fdfl = 1; e_defl = 1; e_own = em; end
          else if (lu) begin e_defl = 1; e_own = em; end
          else if (em) begin e_fden = 1; e_fdfl = 1; e_own = 1; end
          else         begin e_pc = 1; e_fden = 1; end
        end
        M_DRAIN: begin
          e_busy = 1;
          e_own  = em;
          if (br)      begin e_pc = 1; e_fden = 1; e_fdfl = 1; e_defl = 1; end
          else if (lu) begin e_defl = 1; end
          else         begin e_fden = 1; e_fdfl = 1; end
        end
        M_PUSH: begin
          e_busy = 1; e_own = 1; e_fden = 1; e_fdfl = 1; e_defl = 1; e_push = !em;
        end
        default: begin
          e_busy = 1; e_vec = 1; e_pc = 1; e_ack = 1; e_fden = 1; e_fdfl = 1; e_defl = 1;
        end
      endcase
    end
    checkOutput("pc_en",           32'(bus.pc_en),           32'(e_pc));
    checkOutput("fd_en",           32'(bus.fd_en),           32'(e_fden));
    checkOutput("fd_flush",        32'(bus.fd_flush),        32'(e_fdfl));
    checkOutput("de_flush",        32'(bus.de_flush),        32'(e_defl));
    checkOutput("mem_owner",       32'(bus.mem_owner),       32'(e_own));
    checkOutput("int_push",        32'(bus.int_push),        32'(e_push));
    checkOutput("int_vector_load", 32'(bus.int_vector_load), 32'(e_vec));
    checkOutput("int_ack",         32'(bus.int_ack),         32'(e_ack));
    checkOutput("busy",            32'(bus.busy),            32'(e_busy));
    checkOutput("stall_count",     32'(bus.stall_count),     32'(exp_stall));
    @(posedge clk);
    if (rst) begin
      mode       = M_RUN;
      drain_left = 0;
    end else begin
      case (mode)
        M_RUN: if (irq && !br) begin mode = M_DRAIN; drain_left = DRAIN; end
        M_DRAIN: begin
          if (br || !lu) drain_left--;
          if (drain_left == 0) mode = M_PUSH;
        end
        M_PUSH: if (!em) mode = M_VEC;
        default: mode = M_RUN;
      endcase
    end
`ifdef HAZARD_PERF_CNT_EN
    if (rst) exp_stall = '0;
    else if (!e_pc && (exp_stall != {PW{1'b1}})) exp_stall = exp_stall + 1'b1;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idleUntilPush();
    for (int i = 0; i < 12 && mode != M_PUSH; i++) idle(1);
    checkOutput("reach_push", 32'(mode), 32'(M_PUSH));
  endtask

  initial begin
    logic [RW-1:0] s1, s2, dst;
    logic s1v, s2v, mr, em, br, irq, rst;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // load-use on src1
    applyStimulus(0, 3, 1, 0, 0, 1, 3, 0, 0, 0);
    idle(1);
    // load-use on src2 only, and a near miss on src1
    applyStimulus(0, 2, 1, 5, 1, 1, 5, 0, 0, 0);
    applyStimulus(0, 5, 0, 1, 1, 1, 5, 0, 0, 0);
    // memory stage owns the port for two cycles
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // branch + load-use + memory access together
    applyStimulus(0, 3, 1, 0, 0, 1, 3, 1, 1, 0);
    idle(1);
    // interrupt entry, plain
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(6);
    // interrupt deferred by a branch, then taken
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(6);
    // load-use in first drain cycle, memory access delays the push
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 4, 1, 0, 0, 1, 4, 0, 0, 0);
    idleUntilPush();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // reset in the middle of INT_PUSH
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idleUntilPush();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      s1  = RW'($urandom);
      s2  = RW'($urandom);
      s1v = $urandom_range(0, 1);
      s2v = $urandom_range(0, 1);
      mr  = ($urandom_range(0, 2) == 0);
      dst = ($urandom_range(0, 1) == 0) ? s1 : RW'($urandom);
      em  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 5) == 0);
      irq = ($urandom_range(0, 9) == 0);
      if (mode == M_DRAIN && br) mr = 1'b0;
      applyStimulus(rst, s1, s1v, s2, s2v, mr, dst, em, br, irq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
